// File: rtl/cram_arb_pkg.sv
// Shared types and constants for the cram_arb data RAM.
package cram_arb_pkg;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 4;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CPU,
        ARB_DEBUG,
        ARB_FORCE
    } arb_e;

    typedef enum logic {
        MODE_CLEAR,
        MODE_RUN
    } mode_e;

endpackage

// File: rtl/cram_arb_store.sv
// Single-port synchronous RAM with per-byte write enables; read data lands one cycle after en_i.
module cram_arb_store
    import cram_arb_pkg::*;
#(
    parameter int unsigned p_data_width    = 16,
    parameter int unsigned p_address_width = 10,
    localparam int unsigned NB             = p_data_width / BYTE_W
) (
    input  logic                       clk_i,
    input  logic                       en_i,
    input  logic                       we_i,
    input  logic [NB-1:0]              be_i,
    input  logic [p_address_width-1:0] addr_i,
    input  logic [p_data_width-1:0]    wdata_i,
    output logic [p_data_width-1:0]    rdata_o
);

    logic [p_data_width-1:0] mem_q [0:(1 << p_address_width) - 1];
    logic [p_data_width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cram_arb.sv
// CPU data RAM: handshaked CPU port plus starvation-bounded debug read port over one storage array.
// Optional CRAM_CLEAR_ON_RESET_EN: zero-fill sweep after reset before serving requests.
module cram_arb
    import cram_arb_pkg::*;
#(
    parameter int unsigned p_data_width    = 16,
    parameter int unsigned p_address_width = 10,
    parameter int unsigned p_read_latency  = 2,
    parameter int unsigned p_starve_limit  = 8
) (
    input  logic                         i_w_clk,
    input  logic                         i_w_reset,
    input  logic                         i_w_req,
    input  logic                         i_w_we,
    input  logic [p_address_width-1:0]   i_w_address,
    input  logic [p_data_width-1:0]      i_w_in,
    input  logic [p_data_width/8-1:0]    i_w_be,
    output logic                         o_w_ready,
    output logic [p_data_width-1:0]      o_w_out,
    output logic                         o_w_valid,
    input  logic                         i_w_disp_req,
    input  logic [p_address_width-1:0]   i_w_disp_address,
    output logic                         o_w_disp_ack,
    output logic [p_data_width-1:0]      o_w_disp_out,
    output logic                         o_w_disp_valid
);

    localparam int unsigned NB  = p_data_width / BYTE_W;
    localparam int unsigned LAT = (p_read_latency < LAT_MIN) ? LAT_MIN :
                                  (p_read_latency > LAT_MAX) ? LAT_MAX : p_read_latency;
    localparam logic [7:0]  LIMIT = 8'(p_starve_limit);

    mode_e                     mode_q, mode_d;
    arb_e                      arb;
    logic [7:0]                cnt_q, cnt_d;
    logic [LAT-1:0]            cv_q, dv_q;
    logic [p_data_width-1:0]   dhold_q;
    logic                      ram_en, ram_we, cpu_rd;
    logic [NB-1:0]             ram_be;
    logic [p_address_width-1:0] ram_addr;
    logic [p_data_width-1:0]   ram_wdata, ram_rdata, tap;
`ifdef CRAM_CLEAR_ON_RESET_EN
    logic [p_address_width-1:0] sweep_q, sweep_d;
`endif

    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
`ifdef CRAM_CLEAR_ON_RESET_EN
            mode_q  <= MODE_CLEAR;
            sweep_q <= '0;
`else
            mode_q  <= MODE_RUN;
`endif
            cnt_q   <= '0;
            cv_q    <= '0;
            dv_q    <= '0;
            dhold_q <= '0;
        end else begin
`ifdef CRAM_CLEAR_ON_RESET_EN
            sweep_q <= sweep_d;
`endif
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            cv_q[0] <= cpu_rd;
            dv_q[0] <= o_w_disp_ack;
            for (int unsigned i = 1; i < LAT; i++) begin
                cv_q[i] <= cv_q[i-1];
                dv_q[i] <= dv_q[i-1];
            end
            if (o_w_disp_valid) dhold_q <= tap;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        arb       = ARB_IDLE;
        cnt_d     = cnt_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = i_w_be;
        ram_addr  = i_w_address;
        ram_wdata = i_w_in;
`ifdef CRAM_CLEAR_ON_RESET_EN
        sweep_d   = sweep_q;
`endif
        if (mode_q == MODE_RUN && !i_w_reset) begin
            if (i_w_disp_req && cnt_q == LIMIT) arb = ARB_FORCE;
            else if (i_w_req)                   arb = ARB_CPU;
            else if (i_w_disp_req)              arb = ARB_DEBUG;
        end
`ifdef CRAM_CLEAR_ON_RESET_EN
        else if (mode_q == MODE_CLEAR && !i_w_reset) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_be    = '1;
            ram_addr  = sweep_q;
            ram_wdata = '0;
            sweep_d   = sweep_q + 1'b1;
            if (sweep_q == '1) mode_d = MODE_RUN;
        end
`endif
        case (arb)
            ARB_CPU: begin
                ram_en = 1'b1;
                ram_we = i_w_we;
                if (i_w_disp_req && cnt_q != LIMIT) cnt_d = cnt_q + 8'd1;
            end
            ARB_DEBUG, ARB_FORCE: begin
                ram_en   = 1'b1;
                ram_addr = i_w_disp_address;
                cnt_d    = '0;
            end
            default: ;
        endcase
        if (!i_w_disp_req) cnt_d = '0;
        o_w_ready    = (mode_q == MODE_RUN) && !i_w_reset && (arb != ARB_FORCE);
        o_w_disp_ack = (arb == ARB_DEBUG) || (arb == ARB_FORCE);
        cpu_rd       = (arb == ARB_CPU) && !i_w_we;
    end

    cram_arb_store #(
        .p_data_width   (p_data_width),
        .p_address_width(p_address_width)
    ) u_store (
        .clk_i  (i_w_clk),
        .en_i   (ram_en),
        .we_i   (ram_we),
        .be_i   (ram_be),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    // Data stages need no reset: every output is qualified by the reset-cleared valid pipes.
    if (LAT == 1) begin : g_lat1
        assign tap = ram_rdata;
    end else begin : g_latn
        logic [p_data_width-1:0] pd_q [LAT-1];
        always_ff @(posedge i_w_clk) begin
            pd_q[0] <= ram_rdata;
            for (int unsigned i = 1; i < LAT - 1; i++) pd_q[i] <= pd_q[i-1];
        end
        assign tap = pd_q[LAT-2];
    end

    assign o_w_valid      = cv_q[LAT-1];
    assign o_w_out        = o_w_valid ? tap : '0;
    assign o_w_disp_valid = dv_q[LAT-1];
    assign o_w_disp_out   = o_w_disp_valid ? tap : dhold_q;

endmodule

// File: tb/tb_cram_arb.sv
// Directed self-checking bench for cram_arb (latency 3, starve limit 4, 16 words).
module tb_cram_arb;

    logic        clk = 1'b0;
    logic        rst, req, we, dreq;
    logic [3:0]  addr, daddr;
    logic [15:0] din;
    logic [1:0]  be;
    logic        ready, valid, ack, dvalid;
    logic [15:0] dout, ddout;
    logic [15:0] mem_exp [8];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cram_arb #(
        .p_data_width   (16),
        .p_address_width(4),
        .p_read_latency (3),
        .p_starve_limit (4)
    ) dut (
        .i_w_clk         (clk),
        .i_w_reset       (rst),
        .i_w_req         (req),
        .i_w_we          (we),
        .i_w_address     (addr),
        .i_w_in          (din),
        .i_w_be          (be),
        .o_w_ready       (ready),
        .o_w_out         (dout),
        .o_w_valid       (valid),
        .i_w_disp_req    (dreq),
        .i_w_disp_address(daddr),
        .o_w_disp_ack    (ack),
        .o_w_disp_out    (ddout),
        .o_w_disp_valid  (dvalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic r, input logic w, input logic [3:0] a, input logic [15:0] d,
                       input logic [1:0] b, input logic dr, input logic [3:0] da);
        req = r; we = w; addr = a; din = d; be = b; dreq = dr; daddr = da;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 4'd0, 16'd0, 2'd0, 1'b0, 4'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        drv(1'b1, 1'b0, a, 16'd0, 2'd0, 1'b0, 4'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
        drv(1'b1, 1'b1, a, d, b, 1'b0, 4'd0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !ready; i++) begin
            tick();
            idle();
        end
        chk("ready_after_sweep", ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        chk("ready_in_reset", ready, 0);
        tick(); idle();
        tick();
        rst = 1'b0;
        idle();
`ifdef CRAM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 16; i++) begin
            chk("sweep_ready_low", ready, 0);
            tick(); idle();
        end
`endif
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_out", dout, 0);
        chk("rst_ack", ack, 0);
        chk("rst_dvalid", dvalid, 0);
        chk("rst_dout", ddout, 0);

`ifdef CRAM_CLEAR_ON_RESET_EN
        for (int c = 0; c < 19; c++) begin
            if (c < 16) rd(4'(c)); else idle();
            if (c >= 3) begin
                chk("sweep_rd_valid", valid, 1);
                chk("sweep_rd_zero", dout, 0);
            end
            tick();
        end
        idle();
`endif

        // latency: write at T, read at T+1, data at T+4
        wr(4'd5, 16'hBEEF, 2'b11);
        chk("lat_wr_ready", ready, 1);
        tick(); rd(4'd5);
        tick(); idle();
        chk("lat_t2_valid", valid, 0);
        tick(); idle();
        chk("lat_t3_valid", valid, 0);
        chk("lat_t3_out", dout, 0);
        tick(); idle();
        chk("lat_t4_valid", valid, 1);
        chk("lat_t4_out", dout, 16'hBEEF);
        tick(); idle();
        chk("lat_t5_valid", valid, 0);
        chk("lat_t5_out", dout, 0);

        // byte enables, including be=0 no-op write
        tick(); wr(4'd7, 16'h1234, 2'b11);
        tick(); wr(4'd7, 16'hAB00, 2'b10);
        tick(); rd(4'd7);
        tick(); idle(); tick(); idle(); tick(); idle();
        chk("be_valid", valid, 1);
        chk("be_merge", dout, 16'hAB34);
        tick(); wr(4'd7, 16'hFFFF, 2'b00);
        chk("be0_ready", ready, 1);
        tick(); rd(4'd7);
        tick(); idle(); tick(); idle(); tick(); idle();
        chk("be0_noop", dout, 16'hAB34);

        // pipelining: 8 back-to-back reads
        mem_exp[5] = 16'hBEEF;
        mem_exp[7] = 16'hAB34;
        for (int i = 0; i < 8; i++) begin
            if (i != 5 && i != 7) begin
                mem_exp[i] = 16'h1111 * 16'(i + 1);
                tick(); wr(4'(i), mem_exp[i], 2'b11);
            end
        end
        tick();
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                rd(4'(c));
                chk("pipe_ready", ready, 1);
            end else begin
                idle();
            end
            if (c >= 3) begin
                chk("pipe_valid", valid, 1);
                chk("pipe_data", dout, 32'(mem_exp[c-3]));
            end
            tick();
        end
        idle();
        chk("pipe_drained", valid, 0);

        // plain debug grant, then display data hold
        tick(); drv(1'b0, 1'b0, 4'd0, 16'd0, 2'd0, 1'b1, 4'd5);
        chk("dbg_ack", ack, 1);
        tick(); idle(); tick(); idle(); tick(); idle();
        chk("dbg_dvalid", dvalid, 1);
        chk("dbg_dout", ddout, 16'hBEEF);
        tick(); idle();
        chk("dbg_dvalid_pulse", dvalid, 0);
        chk("dbg_hold", ddout, 16'hBEEF);

        // starvation: forced grant on 5th contended cycle
        tick();
        for (int k = 1; k <= 4; k++) begin
            drv(1'b1, 1'b0, 4'd0, 16'd0, 2'd0, 1'b1, 4'd7);
            chk("starve_ack_low", ack, 0);
            chk("starve_ready_high", ready, 1);
            tick();
        end
        drv(1'b1, 1'b0, 4'd0, 16'd0, 2'd0, 1'b1, 4'd7);
        chk("force_ack", ack, 1);
        chk("force_ready", ready, 0);
        tick(); rd(4'd1);
        chk("after_force_ready", ready, 1);
        chk("after_force_ack", ack, 0);
        tick(); rd(4'd2);
        tick(); idle();
        chk("force_dvalid", dvalid, 1);
        chk("force_dout", ddout, 16'hAB34);
        chk("force_cpu_gap", valid, 0);
        tick(); idle();
        chk("force_dvalid_pulse", dvalid, 0);
        chk("force_dhold", ddout, 16'hAB34);
        chk("cpu_resume_valid", valid, 1);
        chk("cpu_resume_data", dout, 32'(mem_exp[1]));
        tick(); idle(); tick(); idle(); tick(); idle();

        // reset with two reads in flight
        tick(); rd(4'd5);
        tick(); rd(4'd7);
        tick();
        rst = 1'b1;
        idle();
        chk("midrst_ready", ready, 0);
        tick();
        rst = 1'b0;
        idle();
        chk("midrst_dout_cleared", ddout, 0);
`ifdef CRAM_CLEAR_ON_RESET_EN
        wait_ready();
`endif
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_valid", valid, 0);
            tick(); idle();
        end
        rd(4'd7);
        tick(); idle(); tick(); idle(); tick(); idle();
        chk("retained_valid", valid, 1);
`ifdef CRAM_CLEAR_ON_RESET_EN
        chk("retained_data", dout, 0);
`else
        chk("retained_data", dout, 16'hAB34);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
